// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Parallel-to-serial stage feeding the overlapping sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// `data`. A one-entry holding buffer plus a bypass path let consecutive
// words stream with no idle cycles between them.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   din         parallel word to serialise (sampled only on accept)
//   din_valid   din is valid this cycle
//   din_ready   word can be accepted this cycle (= !hold_full)
//   data        registered serial bit stream
//   data_valid  registered, high while data carries a word bit
//   word_done   registered, high while data carries the last bit of a word
//   busy        high while shifting or while the holding buffer is occupied
//
// State table:
//   state | meaning
//   IDLE  | nothing on data, data = IDLE_BIT
//   SHIFT | data carries bit cnt of the word in flight
module serial_bit_feeder #(
    parameter int       WIDTH     = 8,
    parameter bit       MSB_FIRST = 1'b1,
    parameter logic     IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             data,
    output logic             data_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             data_n, data_valid_n, word_done_n;
    logic             accept;

    // The bit currently on `data` has already been removed from the shifter,
    // so the shifter always presents the next bit at its output end.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w[WIDTH-1];
        else           return w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w << 1;
        else           return w >> 1;
    endfunction

    assign din_ready = ~hold_full;
    assign accept    = din_valid & ~hold_full;
    assign busy      = (state == SHIFT) | hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            cnt        <= '0;
            data       <= IDLE_BIT;
            data_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            hold       <= hold_n;
            hold_full  <= hold_full_n;
            cnt        <= cnt_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            word_done  <= word_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        hold_n       = hold;
        hold_full_n  = hold_full;
        cnt_n        = cnt;
        data_n       = data;
        data_valid_n = data_valid;
        word_done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    data_n       = first_bit(din);
                    shreg_n      = advance(din);
                    cnt_n        = '0;
                    data_valid_n = 1'b1;
                    state_n      = SHIFT;
                end else begin
                    data_n       = IDLE_BIT;
                    data_valid_n = 1'b0;
                end
            end

            SHIFT: begin
                if (cnt != LAST) begin
                    data_n       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                    shreg_n      = advance(shreg);
                    cnt_n        = cnt + CNT_W'(1);
                    data_valid_n = 1'b1;
                    word_done_n  = (cnt_n == LAST);
                    if (accept) begin
                        hold_n      = din;
                        hold_full_n = 1'b1;
                    end
                end else if (hold_full) begin
                    data_n       = first_bit(hold);
                    shreg_n      = advance(hold);
                    cnt_n        = '0;
                    hold_full_n  = 1'b0;
                    data_valid_n = 1'b1;
                end else if (accept) begin
                    // bypass: next word goes straight into the shifter
                    data_n       = first_bit(din);
                    shreg_n      = advance(din);
                    cnt_n        = '0;
                    data_valid_n = 1'b1;
                end else begin
                    data_n       = IDLE_BIT;
                    data_valid_n = 1'b0;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end
            end

            default: begin
                state_n      = IDLE;
                data_n       = IDLE_BIT;
                data_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] din_a = '0;
    logic       din_valid_a = 1'b0;
    logic       din_ready_a, data_a, data_valid_a, word_done_a, busy_a;

    logic [7:0] din_b = '0;
    logic       din_valid_b = 1'b0;
    logic       din_ready_b, data_b, data_valid_b, word_done_b, busy_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_bits;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .rst(rst),
        .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
        .data(data_a), .data_valid(data_valid_a), .word_done(word_done_a),
        .busy(busy_a)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .data(data_b), .data_valid(data_valid_b), .word_done(word_done_b),
        .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_data", data_a, 1'b0);
        chk("rst_dv", data_valid_a, 1'b0);
        chk("rst_wd", word_done_a, 1'b0);
        chk("rst_ready", din_ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        tick();
        tick();
        rst = 1'b1;

        // idle stream: 20 cycles without din_valid
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_data", data_a, 1'b0);
            chk("idle_dv", data_valid_a, 1'b0);
            chk("idle_wd", word_done_a, 1'b0);
            chk("idle_data_lsb", data_b, 1'b0);
        end

        // single word 8'hB4, MSB first
        exp_bits = 16'hB400;
        din_a = 8'hB4; din_valid_a = 1'b1;
        chk("single_ready", din_ready_a, 1'b1);
        tick();
        din_valid_a = 1'b0; din_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("single_data", data_a, exp_bits[15-i]);
            chk("single_dv", data_valid_a, 1'b1);
            chk("single_wd", word_done_a, (i == 7) ? 1'b1 : 1'b0);
            chk("single_busy", busy_a, 1'b1);
            tick();
        end
        chk("single_after_data", data_a, 1'b0);
        chk("single_after_dv", data_valid_a, 1'b0);
        chk("single_after_wd", word_done_a, 1'b0);
        chk("single_after_busy", busy_a, 1'b0);
        tick();

        // back-to-back 8'hB4 then 8'h2D through the holding buffer
        exp_bits = 16'b1011010000101101;
        din_a = 8'hB4; din_valid_a = 1'b1;
        tick();
        din_a = 8'h2D;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_data", data_a, exp_bits[15-i]);
            chk("b2b_dv", data_valid_a, 1'b1);
            chk("b2b_wd", word_done_a, (i == 7 || i == 15) ? 1'b1 : 1'b0);
            chk("b2b_ready", din_ready_a, (i >= 1 && i <= 7) ? 1'b0 : 1'b1);
            chk("b2b_busy", busy_a, 1'b1);
            tick();
            if (i == 0) begin
                din_valid_a = 1'b0; din_a = 8'h00;
            end
        end
        chk("b2b_after_dv", data_valid_a, 1'b0);
        chk("b2b_after_data", data_a, 1'b0);
        tick();

        // bypass: 8'h81, then 8'hF0 presented on the last-bit cycle
        exp_bits = 16'b1000000111110000;
        din_a = 8'h81; din_valid_a = 1'b1;
        tick();
        din_valid_a = 1'b0; din_a = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                din_a = 8'hF0; din_valid_a = 1'b1;
            end
            chk("byp_data", data_a, exp_bits[15-i]);
            chk("byp_dv", data_valid_a, 1'b1);
            chk("byp_wd", word_done_a, (i == 7 || i == 15) ? 1'b1 : 1'b0);
            chk("byp_ready", din_ready_a, 1'b1);
            tick();
            if (i == 7) begin
                din_valid_a = 1'b0; din_a = 8'h00;
            end
        end
        chk("byp_after_dv", data_valid_a, 1'b0);
        chk("byp_after_busy", busy_a, 1'b0);
        tick();

        // LSB first, 8'h0D -> 1,0,1,1,0,0,0,0
        exp_bits = 16'b1011000000000000;
        din_b = 8'h0D; din_valid_b = 1'b1;
        tick();
        din_valid_b = 1'b0; din_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_data", data_b, exp_bits[15-i]);
            chk("lsb_dv", data_valid_b, 1'b1);
            chk("lsb_wd", word_done_b, (i == 7) ? 1'b1 : 1'b0);
            tick();
        end
        chk("lsb_after_dv", data_valid_b, 1'b0);
        chk("lsb_after_data", data_b, 1'b0);
        tick();

        // reset mid-word: 8'hFF in flight, 8'hAA in the hold
        din_a = 8'hFF; din_valid_a = 1'b1;
        tick();
        din_a = 8'hAA;
        chk("mid_bit0", data_a, 1'b1);
        tick();
        din_valid_a = 1'b0; din_a = 8'h00;
        chk("mid_bit1", data_a, 1'b1);
        chk("mid_ready_held", din_ready_a, 1'b0);
        tick();
        chk("mid_bit2", data_a, 1'b1);
        chk("mid_busy", busy_a, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_data", data_a, 1'b0);
        chk("mid_rst_dv", data_valid_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_ready", din_ready_a, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("post_rst_dv", data_valid_a, 1'b0);
            chk("post_rst_data", data_a, 1'b0);
            chk("post_rst_ready", din_ready_a, 1'b1);
            chk("post_rst_busy", busy_a, 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage that sits directly upstream of the overlapping sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on `data`, which wires straight into the detector's `data` input.
- A one-entry holding buffer plus a bypass path let consecutive words stream with no idle cycles between them, so patterns that span a word boundary are still presented contiguously.

Parameters:
- WIDTH, 8: word width in bits. Must be at least 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.
- IDLE_BIT, 0: value driven on `data` while no word is being transmitted.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialise.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  block can accept a word this cycle. Combinational: equals NOT hold_full.
- data  output  1  registered serial bit stream, feeds the detector.
- data_valid  output  1  registered; high while `data` carries a word bit.
- word_done  output  1  registered; high in the cycle `data` carries the last bit of a word.
- busy  output  1  high while shifting or while the holding buffer is occupied.

Behaviour:
- Reset, asynchronous while rst=0:
  - data=IDLE_BIT, data_valid=0, word_done=0.
  - Shifter, bit counter and holding buffer are cleared; hold_full=0, so din_ready=1.
  - State = IDLE. Any in-flight or held word is discarded.
- Handshake:
  - A word is accepted on a rising edge where din_valid=1 and din_ready=1.
  - `din` is only sampled on accept. din_valid may drop or stay high freely.
- State machine (IDLE, SHIFT), with internal bit counter cnt from 0 to WIDTH-1:
  - IDLE, accept: the word loads into the shifter on the same edge. `data` takes its first bit, data_valid=1, cnt=0, state -> SHIFT. Latency: the first bit is visible in the cycle right after the accept edge.
  - IDLE, no accept: data=IDLE_BIT, data_valid=0.
  - SHIFT with cnt < WIDTH-1: each edge advances to the next bit and increments cnt. An accept in this state writes the holding buffer and sets hold_full=1.
  - SHIFT with cnt = WIDTH-1 (last-bit cycle): word_done=1 during this cycle. At the closing edge:
    - If hold_full=1: the held word loads into the shifter, its first bit is driven, cnt=0, hold_full clears.
    - Else if an accept occurs on this edge: bypass, the accepted word loads directly into the shifter, nothing goes to the hold.
    - Else: data=IDLE_BIT, data_valid=0, state -> IDLE.
- Throughput: the words are output with no gap cycles between them as long as each next word arrives by the last-bit cycle of the current one.
- Backpressure:
  - din_ready=0 only while hold_full=1.
  - Because din_ready is NOT hold_full, no accept can happen on the edge that empties the hold. din_ready returns to 1 in the following cycle.
- Bit order:
  - MSB_FIRST=1 sends din[WIDTH-1] down to din[0].
  - MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
- busy = (state==SHIFT) OR hold_full.
- data_valid and word_done change only on clock edges, or asynchronously on reset.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, accept 8'hB4 → data = 1,0,1,1,0,1,0,0 over 8 consecutive cycles starting the cycle after accept. data_valid=1 for exactly those 8 cycles, word_done=1 only on the 8th. Afterwards data=0 and data_valid=0.
- Back-to-back: offer 8'hB4, then 8'h2D held on din_valid from the next cycle → 8'h2D goes to the hold and din_ready=0 until the first word's last-bit edge. Output is 16 contiguous valid bits 1011010000101101 and word_done pulses on bits 8 and 16.
- Bypass: accept 8'h81, then with the hold empty present 8'hF0 exactly on 8'h81's last-bit cycle → 8'hF0 loads directly, no gap in data_valid, hold_full stays 0.
- LSB first, MSB_FIRST=0, accept 8'h0D → data = 1,0,1,1,0,0,0,0.
- Reset mid-word: accept 8'hFF, let 3 bits go out, queue 8'hAA in the hold, pull rst low → data=0, data_valid=0, busy=0 immediately. After release din_ready=1 and no bits from either word appear.
- Idle stream: no din_valid for 20 cycles after reset → data constantly IDLE_BIT, data_valid=0, word_done=0.
